hit_arbiter: RTL and testbench

Sequences hit events from the hit detector into health and block updates for both fighters. Edge-detects each player's has-been-hit flag, enforces per-player invulnerability frames, converts blocked hits into block-meter consumption, and arbitrates simultaneous hits. It sits between `HitDetect` and `health_status` on the 60 Hz effective game clock, so one cycle is one game frame.

---
 rtl/hit_arbiter.sv | 151 +++++++++++++++
 tb/tb_hit_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hit_arbiter.sv
// Turns hit-detector flags into damage/block pulses with invulnerability frames and simultaneous-hit arbitration.
// Define HIT_TRADE_EN to let simultaneous hits trade; otherwise a round-robin pointer defers one hit by a frame.
module hit_arbiter #(
   parameter int IFRAMES = 30,
   parameter int CNT_W   = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_active,
   input  logic [1:0] p1_hit_flag,
   input  logic [1:0] p2_hit_flag,
   input  logic       p1_blocking,
   input  logic       p2_blocking,
   input  logic [2:0] p1_block_left,
   input  logic [2:0] p2_block_left,
   output logic       p1_dmg_pulse,
   output logic       p2_dmg_pulse,
   output logic [1:0] p1_dmg_amt,
   output logic [1:0] p2_dmg_amt,
   output logic       p1_block_pulse,
   output logic       p2_block_pulse,
   output logic       p1_invuln,
   output logic       p2_invuln,
   output logic       trade
);

   typedef enum logic [1:0] {IDLE, PENDING, RESOLVE, INVULN} state_t;

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(IFRAMES);

   state_t           st1_q, st2_q, st1_d, st2_d;
   logic [1:0]       prev1_q, prev2_q;
   logic [CNT_W-1:0] cnt1_q, cnt2_q, cnt1_d, cnt2_d;
   logic             hit1, hit2, acc1, acc2, pend1, pend2;
   logic             res1, res2, dir1, dir2, def1, def2;
   logic             blk1_d, blk2_d, dmg1_d, dmg2_d, trade_d;
   logic [1:0]       amt1_d, amt2_d;
`ifndef HIT_TRADE_EN
   logic             rr_q, rr_d, pend_dir_q, pend_dir_d, contested;
`endif

   function automatic state_t next_state(state_t st, logic active, logic defer,
                                         logic res, logic [CNT_W-1:0] cnt);
      next_state = st;
      if (!active)
         next_state = IDLE;
      else if (defer)
         next_state = PENDING;
      else if (res)
         next_state = RESOLVE;
      else if (st == RESOLVE)
         next_state = (IFRAMES > 0) ? INVULN : IDLE;
      else if ((st == INVULN) && (cnt <= CNT_W'(1)))
         next_state = IDLE;
   endfunction

   // A resolving hit reloads the counter; otherwise it counts down to zero.
   function automatic logic [CNT_W-1:0] next_cnt(logic active, logic res, logic [CNT_W-1:0] cnt);
      if (!active)
         next_cnt = '0;
      else if (res)
         next_cnt = LOAD;
      else if (cnt != '0)
         next_cnt = cnt - CNT_W'(1);
      else
         next_cnt = cnt;
   endfunction

   always_comb begin
      hit1  = (p1_hit_flag != 2'b00) && (prev1_q == 2'b00);
      hit2  = (p2_hit_flag != 2'b00) && (prev2_q == 2'b00);
      pend1 = (st1_q == PENDING);
      pend2 = (st2_q == PENDING);
      acc1  = hit1 && game_active && (cnt1_q == '0) && !pend1;
      acc2  = hit2 && game_active && (cnt2_q == '0) && !pend2;
`ifdef HIT_TRADE_EN
      def1    = 1'b0;
      def2    = 1'b0;
      res1    = acc1;
      res2    = acc2;
      dir1    = p1_hit_flag[1];
      dir2    = p2_hit_flag[1];
      trade_d = acc1 && acc2;
`else
      // On a contested frame the player named by rr resolves now, the other waits one frame.
      contested  = acc1 && acc2;
      def1       = contested && rr_q;
      def2       = contested && !rr_q;
      res1       = (acc1 && !def1) || (pend1 && game_active);
      res2       = (acc2 && !def2) || (pend2 && game_active);
      dir1       = pend1 ? pend_dir_q : p1_hit_flag[1];
      dir2       = pend2 ? pend_dir_q : p2_hit_flag[1];
      rr_d       = contested ? !rr_q : rr_q;
      pend_dir_d = def1 ? p1_hit_flag[1] : (def2 ? p2_hit_flag[1] : pend_dir_q);
      trade_d    = 1'b0;
`endif
      blk1_d = res1 && p1_blocking && (p1_block_left != 3'd0);
      blk2_d = res2 && p2_blocking && (p2_block_left != 3'd0);
      dmg1_d = res1 && !blk1_d;
      dmg2_d = res2 && !blk2_d;
      amt1_d = dmg1_d ? (dir1 ? 2'd2 : 2'd1) : 2'd0;
      amt2_d = dmg2_d ? (dir2 ? 2'd2 : 2'd1) : 2'd0;
      st1_d  = next_state(st1_q, game_active, def1, res1, cnt1_q);
      st2_d  = next_state(st2_q, game_active, def2, res2, cnt2_q);
      cnt1_d = next_cnt(game_active, res1, cnt1_q);
      cnt2_d = next_cnt(game_active, res2, cnt2_q);
   end

   // prev_flag tracks the live flags even in reset, so a flag held through reset is not an edge.
   always_ff @(posedge clk) begin
      prev1_q <= p1_hit_flag;
      prev2_q <= p2_hit_flag;
      if (rst) begin
         st1_q          <= IDLE;
         st2_q          <= IDLE;
         cnt1_q         <= '0;
         cnt2_q         <= '0;
         p1_dmg_pulse   <= 1'b0;
         p2_dmg_pulse   <= 1'b0;
         p1_dmg_amt     <= 2'd0;
         p2_dmg_amt     <= 2'd0;
         p1_block_pulse <= 1'b0;
         p2_block_pulse <= 1'b0;
         trade          <= 1'b0;
`ifndef HIT_TRADE_EN
         rr_q           <= 1'b0;
         pend_dir_q     <= 1'b0;
`endif
      end else begin
         st1_q          <= st1_d;
         st2_q          <= st2_d;
         cnt1_q         <= cnt1_d;
         cnt2_q         <= cnt2_d;
         p1_dmg_pulse   <= dmg1_d;
         p2_dmg_pulse   <= dmg2_d;
         p1_dmg_amt     <= amt1_d;
         p2_dmg_amt     <= amt2_d;
         p1_block_pulse <= blk1_d;
         p2_block_pulse <= blk2_d;
         trade          <= trade_d;
`ifndef HIT_TRADE_EN
         rr_q           <= rr_d;
         pend_dir_q     <= pend_dir_d;
`endif
      end
   end

   assign p1_invuln = (cnt1_q != '0);
   assign p2_invuln = (cnt2_q != '0);

endmodule

// File: tb/tb_hit_arbiter.sv
// Drives hit_arbiter with directed scenarios then random frames, comparing every output
// each frame against a frame-level model of hits, invulnerability windows and deferral.
module tb_hit_arbiter;
   localparam int IFRAMES = 4;
   localparam int CNT_W   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1, game_active = 1'b0;
   logic [1:0] p1_hit_flag = 2'b00, p2_hit_flag = 2'b00;
   logic       p1_blocking = 1'b0, p2_blocking = 1'b0;
   logic [2:0] p1_block_left = 3'd0, p2_block_left = 3'd0;
   logic       p1_dmg_pulse, p2_dmg_pulse, p1_block_pulse, p2_block_pulse;
   logic [1:0] p1_dmg_amt, p2_dmg_amt;
   logic       p1_invuln, p2_invuln, trade;

   int tests_run = 0;
   int tests_failed = 0;

   int         m_inv [2];
   logic [1:0] m_prev [2];
   bit         m_pend = 1'b0;
   int         m_pend_p = 0;
   bit         m_pend_dir = 1'b0;
   int         m_rr = 0;
   bit         e_dmg [2];
   logic [1:0] e_amt [2];
   bit         e_blk [2];
   bit         e_trade;

   hit_arbiter #(.IFRAMES(IFRAMES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .game_active(game_active),
      .p1_hit_flag(p1_hit_flag), .p2_hit_flag(p2_hit_flag),
      .p1_blocking(p1_blocking), .p2_blocking(p2_blocking),
      .p1_block_left(p1_block_left), .p2_block_left(p2_block_left),
      .p1_dmg_pulse(p1_dmg_pulse), .p2_dmg_pulse(p2_dmg_pulse),
      .p1_dmg_amt(p1_dmg_amt), .p2_dmg_amt(p2_dmg_amt),
      .p1_block_pulse(p1_block_pulse), .p2_block_pulse(p2_block_pulse),
      .p1_invuln(p1_invuln), .p2_invuln(p2_invuln), .trade(trade)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // A resolved hit either eats a block unit or deals damage, then opens the invulnerability window.
   task automatic resolveHit(input int i, input bit dir);
      bit         blocking;
      logic [2:0] left;
      blocking = (i == 0) ? p1_blocking : p2_blocking;
      left     = (i == 0) ? p1_block_left : p2_block_left;
      if (blocking && left != 3'd0)
         e_blk[i] = 1'b1;
      else begin
         e_dmg[i] = 1'b1;
         e_amt[i] = dir ? 2'd2 : 2'd1;
      end
      m_inv[i] = IFRAMES;
   endtask

   task automatic modelFrame();
      logic [1:0] fl [2];
      bit         acc [2];
      int         first;
      fl[0] = p1_hit_flag;
      fl[1] = p2_hit_flag;
      e_trade = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e_dmg[i] = 1'b0;
         e_amt[i] = 2'd0;
         e_blk[i] = 1'b0;
      end
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_inv[i]  = 0;
            m_prev[i] = fl[i];
         end
         m_pend = 1'b0;
         m_rr   = 0;
         return;
      end
      for (int i = 0; i < 2; i++) begin
         acc[i] = (fl[i] != 2'b00) && (m_prev[i] == 2'b00) && game_active &&
                  (m_inv[i] == 0) && !(m_pend && m_pend_p == i);
         m_inv[i] = (game_active && m_inv[i] > 0) ? m_inv[i] - 1 : 0;
      end
      if (!game_active)
         m_pend = 1'b0;
      else begin
         if (m_pend) begin
            resolveHit(m_pend_p, m_pend_dir);
            m_pend = 1'b0;
         end
         if (acc[0] && acc[1]) begin
`ifdef HIT_TRADE_EN
            resolveHit(0, fl[0][1]);
            resolveHit(1, fl[1][1]);
            e_trade = 1'b1;
`else
            first = m_rr;
            resolveHit(first, fl[first][1]);
            m_pend     = 1'b1;
            m_pend_p   = 1 - first;
            m_pend_dir = fl[1 - first][1];
            m_rr       = 1 - m_rr;
`endif
         end else begin
            for (int i = 0; i < 2; i++)
               if (acc[i]) resolveHit(i, fl[i][1]);
         end
      end
      for (int i = 0; i < 2; i++) m_prev[i] = fl[i];
   endtask

   task automatic applyStimulus(input logic r, input logic a, input logic [1:0] f1, input logic [1:0] f2,
                                input logic b1, input logic b2, input logic [2:0] l1, input logic [2:0] l2);
      rst = r;
      game_active = a;
      p1_hit_flag = f1;
      p2_hit_flag = f2;
      p1_blocking = b1;
      p2_blocking = b2;
      p1_block_left = l1;
      p2_block_left = l2;
      modelFrame();
      @(posedge clk);
      #1;
      checkOutput("p1_dmg_pulse", p1_dmg_pulse, e_dmg[0]);
      checkOutput("p1_dmg_amt", p1_dmg_amt, e_amt[0]);
      checkOutput("p1_block_pulse", p1_block_pulse, e_blk[0]);
      checkOutput("p1_invuln", p1_invuln, m_inv[0] != 0);
      checkOutput("p2_dmg_pulse", p2_dmg_pulse, e_dmg[1]);
      checkOutput("p2_dmg_amt", p2_dmg_amt, e_amt[1]);
      checkOutput("p2_block_pulse", p2_block_pulse, e_blk[1]);
      checkOutput("p2_invuln", p2_invuln, m_inv[1] != 0);
      checkOutput("trade", trade, e_trade);
   endtask

   task automatic idleFrames(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, 1, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
   endtask

   initial begin
      logic       r, a, b1, b2;
      logic [1:0] f1, f2;
      logic [2:0] l1, l2;
      applyStimulus(1, 0, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
      applyStimulus(1, 0, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
      // Single basic hit on P2, then the invulnerability window runs out.
      applyStimulus(0, 1, 2'b00, 2'b01, 0, 0, 3'd0, 3'd0);
      idleFrames(6);
      // Second edge inside the window is dropped, a third after it lands.
      applyStimulus(0, 1, 2'b00, 2'b10, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b00, 2'b10, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b00, 2'b11, 0, 0, 3'd0, 3'd0);
      idleFrames(6);
      // Blocked hit with meter left, then the same hit with an empty meter.
      applyStimulus(0, 1, 2'b01, 2'b00, 1, 0, 3'd3, 3'd0);
      idleFrames(6);
      applyStimulus(0, 1, 2'b01, 2'b00, 1, 0, 3'd0, 3'd0);
      idleFrames(6);
      // Two contested frames: pointer order alternates.
      applyStimulus(0, 1, 2'b01, 2'b10, 0, 0, 3'd0, 3'd0);
      idleFrames(7);
      applyStimulus(0, 1, 2'b10, 2'b01, 0, 1, 3'd0, 3'd2);
      idleFrames(7);
      // Reset lands while P1 counts down and P2 waits; held flags after reset are not edges.
      applyStimulus(0, 1, 2'b01, 2'b01, 0, 0, 3'd0, 3'd0);
      applyStimulus(1, 1, 2'b01, 2'b01, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b01, 2'b01, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b01, 2'b01, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 1, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
      // Edges while the game is inactive are ignored.
      applyStimulus(0, 0, 2'b10, 2'b01, 0, 0, 3'd0, 3'd0);
      applyStimulus(0, 0, 2'b00, 2'b00, 0, 0, 3'd0, 3'd0);
      idleFrames(2);
      for (int k = 0; k < 3000; k++) begin
         r  = ($urandom_range(0, 99) == 0);
         a  = ($urandom_range(0, 19) != 0);
         f1 = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3));
         f2 = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3));
         b1 = $urandom_range(0, 1);
         b2 = $urandom_range(0, 1);
         l1 = $urandom_range(0, 2) == 0 ? 3'd0 : 3'($urandom_range(1, 7));
         l2 = $urandom_range(0, 2) == 0 ? 3'd0 : 3'($urandom_range(1, 7));
         applyStimulus(r, a, f1, f2, b1, b2, l1, l2);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
